// File: rtl/mesm6_fetch_pkg.sv
// Shared types and helpers for the mesm6 instruction fetch unit.
// Provides the fetch FSM state type, opcode/word widths and the
// index/tag split used by both the cache array and the fetch control.
package mesm6_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        PREF = 2'd2
    } fetch_state_e;

    localparam int unsigned HALF_W = 24;
    localparam int unsigned WORD_W = 48;

    // Line index: low idx_w bits of the word address (0 for a single-line cache).
    function automatic logic [31:0] line_index(input logic [31:0] word_addr,
                                               input int unsigned idx_w);
        logic [31:0] mask;
        mask = (idx_w == 0) ? 32'd0 : ((32'd1 << idx_w) - 32'd1);
        return word_addr & mask;
    endfunction

    // Line tag: word address bits above the index.
    function automatic logic [31:0] line_tag(input logic [31:0] word_addr,
                                             input int unsigned idx_w);
        return word_addr >> idx_w;
    endfunction

endpackage

// File: rtl/mesm6_icache_array.sv
// Direct-mapped instruction cache storage: valid/tag/data per line.
// Ports: rd_* demand read port, chk_* tag-only probe port, wr_* line fill,
// inv_* tag-qualified single-line invalidate, clear_all bulk invalidate.
// Invalidate beats a same-cycle fill of the same address; clear_all beats both.
module mesm6_icache_array
    import mesm6_fetch_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned IDX_B = 4,
    parameter int unsigned TAG_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_B-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [WORD_W-1:0] rd_data,
    input  logic [IDX_B-1:0]  chk_idx,
    output logic              chk_valid,
    output logic [TAG_W-1:0]  chk_tag,
    input  logic              wr_en,
    input  logic [IDX_B-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              inv_en,
    input  logic [IDX_B-1:0]  inv_idx,
    input  logic [TAG_W-1:0]  inv_tag,
    input  logic              clear_all
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [WORD_W-1:0] data_q [LINES];
    logic              inv_hit;

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_data   = data_q[rd_idx];
    assign chk_valid = valid_q[chk_idx];
    assign chk_tag   = tag_q[chk_idx];

    // Compare against the tag the line will hold after a same-cycle fill.
    assign inv_hit = inv_en &&
                     ((wr_en && (wr_idx == inv_idx)) ? (wr_tag == inv_tag)
                                                     : (tag_q[inv_idx] == inv_tag));

    // Valid bits.
    always_ff @(posedge clk) begin
        if (reset || clear_all) begin
            valid_q <= '0;
        end else begin
            if (wr_en)   valid_q[wr_idx]  <= 1'b1;
            if (inv_hit) valid_q[inv_idx] <= 1'b0;
        end
    end

    // Tag and data storage; contents are meaningless while the valid bit is 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/mesm6_fetch_unit.sv
// Instruction fetch unit: direct-mapped multi-line opcode cache with optional
// next-word prefetch and data-bus write snooping.
// Ports: req/pc/ready/opcode to the microcode sequencer (combinational hit),
// flush and snoop_write/snoop_addr for coherence, ibus_* to instruction memory.
module mesm6_fetch_unit
    import mesm6_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned LINES    = 16,
    parameter int unsigned PREFETCH = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W:0]   pc,
    output logic              ready,
    output logic [HALF_W-1:0] opcode,
    input  logic              flush,
    input  logic              snoop_write,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              ibus_fetch,
    output logic [ADDR_W-1:0] ibus_addr,
    input  logic [WORD_W-1:0] ibus_input,
    input  logic              ibus_done
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned IDX_B = (IDX_W == 0) ? 1 : IDX_W;
    localparam int unsigned TAG_W = ADDR_W - IDX_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fa_q, pf_addr_q;
    logic              pf_pending_q, stale_q;

    logic [ADDR_W-1:0] pc_word, nxt_word;
    logic [IDX_B-1:0]  pc_idx, fa_idx, nxt_idx, sn_idx;
    logic [TAG_W-1:0]  pc_tag, fa_tag, nxt_tag, sn_tag, rd_tag, chk_tag;
    logic              rd_valid, chk_valid;
    logic [WORD_W-1:0] rd_data;
    logic              hit, demand_miss, pf_go, nxt_cached, fill_en, snoop_fa;

    // Address splits for the demand, fill, next-word and snoop addresses.
    assign pc_word  = pc[ADDR_W:1];
    assign nxt_word = fa_q + ADDR_W'(1);
    assign pc_idx   = IDX_B'(line_index(32'(pc_word), IDX_W));
    assign pc_tag   = TAG_W'(line_tag(32'(pc_word), IDX_W));
    assign fa_idx   = IDX_B'(line_index(32'(fa_q), IDX_W));
    assign fa_tag   = TAG_W'(line_tag(32'(fa_q), IDX_W));
    assign nxt_idx  = IDX_B'(line_index(32'(nxt_word), IDX_W));
    assign nxt_tag  = TAG_W'(line_tag(32'(nxt_word), IDX_W));
    assign sn_idx   = IDX_B'(line_index(32'(snoop_addr), IDX_W));
    assign sn_tag   = TAG_W'(line_tag(32'(snoop_addr), IDX_W));

    assign hit         = req && rd_valid && (rd_tag == pc_tag);
    assign demand_miss = req && !hit;
    assign pf_go       = (PREFETCH != 0) && pf_pending_q && !flush;
    assign nxt_cached  = chk_valid && (chk_tag == nxt_tag);
    assign fill_en     = (state_q != IDLE) && ibus_done && !stale_q;
    assign snoop_fa    = snoop_write && (snoop_addr == fa_q);

    mesm6_icache_array #(
        .LINES (LINES),
        .IDX_B (IDX_B),
        .TAG_W (TAG_W)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (pc_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .chk_idx   (nxt_idx),
        .chk_valid (chk_valid),
        .chk_tag   (chk_tag),
        .wr_en     (fill_en),
        .wr_idx    (fa_idx),
        .wr_tag    (fa_tag),
        .wr_data   (ibus_input),
        .inv_en    (snoop_write),
        .inv_idx   (sn_idx),
        .inv_tag   (sn_tag),
        .clear_all (flush)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: demand misses win over pending prefetch; transfers run to completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (demand_miss)  state_d = MISS;
                else if (pf_go)   state_d = PREF;
            end
            MISS, PREF: begin
                if (ibus_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: bus request from state, opcode from a combinational hit.
    always_comb begin
        ibus_fetch = 1'b0;
        ibus_addr  = '0;
        ready      = 1'b0;
        opcode     = '0;
        if (state_q != IDLE) begin
            ibus_fetch = 1'b1;
            ibus_addr  = fa_q;
        end
        if (hit) begin
            ready  = 1'b1;
            opcode = pc[0] ? rd_data[HALF_W-1:0] : rd_data[WORD_W-1:HALF_W];
        end
    end

    // Fetch address, prefetch bookkeeping and stale-fill tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            fa_q         <= '0;
            pf_addr_q    <= '0;
            pf_pending_q <= 1'b0;
            stale_q      <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                stale_q <= 1'b0;
                if (demand_miss) begin
                    fa_q         <= pc_word;
                    pf_pending_q <= 1'b0;
                end else if (pf_go) begin
                    fa_q <= pf_addr_q;
                end
            end else if (ibus_done) begin
                stale_q <= 1'b0;
                if (state_q == MISS) begin
                    pf_addr_q    <= nxt_word;
                    pf_pending_q <= (PREFETCH != 0) && !nxt_cached;
                end else begin
                    pf_pending_q <= 1'b0;
                end
            end else if (flush || snoop_fa) begin
                stale_q <= 1'b1;
            end
            if (flush) pf_pending_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mesm6_fetch_unit.sv
// Directed bench for mesm6_fetch_unit: a 16-line prefetching instance and a
// single-line non-prefetching instance share the core-side stimulus, each
// with its own memory responder (fixed 3-cycle latency).
module tb_mesm6_fetch_unit;

    localparam int unsigned AW  = 15;
    localparam int          LAT = 3;

    logic          clk = 1'b0;
    logic          reset, req, flush, snoop_write;
    logic [AW:0]   pc;
    logic [AW-1:0] snoop_addr;

    logic          ready, ibus_fetch, ibus_done;
    logic [23:0]   opcode;
    logic [AW-1:0] ibus_addr;
    logic [47:0]   ibus_input;

    logic          ready0, ibus_fetch0, ibus_done0;
    logic [23:0]   opcode0;
    logic [AW-1:0] ibus_addr0;
    logic [47:0]   ibus_input0;

    int total = 0;
    int bad   = 0;
    int fcnt  = 0, fcnt0 = 0;
    int wcnt  = 0, wcnt0 = 0;
    int cyc, base;

    always #5 clk = ~clk;

    mesm6_fetch_unit #(.ADDR_W(AW), .LINES(16), .PREFETCH(1)) u_dut (
        .clk(clk), .reset(reset), .req(req), .pc(pc), .ready(ready), .opcode(opcode),
        .flush(flush), .snoop_write(snoop_write), .snoop_addr(snoop_addr),
        .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr), .ibus_input(ibus_input),
        .ibus_done(ibus_done)
    );

    mesm6_fetch_unit #(.ADDR_W(AW), .LINES(1), .PREFETCH(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req), .pc(pc), .ready(ready0), .opcode(opcode0),
        .flush(flush), .snoop_write(snoop_write), .snoop_addr(snoop_addr),
        .ibus_fetch(ibus_fetch0), .ibus_addr(ibus_addr0), .ibus_input(ibus_input0),
        .ibus_done(ibus_done0)
    );

    function automatic logic [47:0] mem_word(input logic [AW-1:0] a);
        if (a == 15'h0008) return 48'h123456_789ABC;
        return {24'hA00000 | 24'(a), 24'h500000 | 24'(a)};
    endfunction

    // Memory responders: done LAT cycles after the fetch is first seen.
    always @(negedge clk) begin
        if (reset || ibus_done) begin
            ibus_done = 1'b0;
            wcnt      = 0;
        end else if (ibus_fetch) begin
            wcnt = wcnt + 1;
            if (wcnt >= LAT) begin
                ibus_done  = 1'b1;
                ibus_input = mem_word(ibus_addr);
                fcnt       = fcnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset || ibus_done0) begin
            ibus_done0 = 1'b0;
            wcnt0      = 0;
        end else if (ibus_fetch0) begin
            wcnt0 = wcnt0 + 1;
            if (wcnt0 >= LAT) begin
                ibus_done0  = 1'b1;
                ibus_input0 = mem_word(ibus_addr0);
                fcnt0       = fcnt0 + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drain();
        req = 1'b0;
        repeat (10) tick();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 30) begin
            tick();
            n = n + 1;
        end
        chk("wait_ready", 48'(ready), 48'd1);
    endtask

    initial begin
        reset = 1'b1; req = 1'b1; pc = 16'h0011; flush = 1'b0;
        snoop_write = 1'b0; snoop_addr = '0;
        ibus_done = 1'b0; ibus_input = '0; ibus_done0 = 1'b0; ibus_input0 = '0;
        tick(); tick();
        settle();
        chk("rst_ready", 48'(ready), 48'd0);
        chk("rst_opcode", 48'(opcode), 48'd0);
        chk("rst_fetch", 48'(ibus_fetch), 48'd0);

        // Cold miss on pc 0x0011
        reset = 1'b0;
        settle();
        chk("cold_ready0", 48'(ready), 48'd0);
        tick();
        chk("cold_fetch", 48'(ibus_fetch), 48'd1);
        chk("cold_addr", 48'(ibus_addr), 48'h0008);
        wait_ready(cyc);
        chk("cold_latency", 48'(cyc), 48'd3);
        chk("cold_opcode", 48'(opcode), 48'h789ABC);
        chk("l1_opcode", 48'(opcode0), 48'h789ABC);
        pc = 16'h0010;
        settle();
        chk("hit_ready", 48'(ready), 48'd1);
        chk("hit_opcode", 48'(opcode), 48'h123456);
        tick();
        chk("pf_fetch", 48'(ibus_fetch), 48'd1);
        chk("pf_addr", 48'(ibus_addr), 48'h0009);
        chk("l1_nopf", 48'(ibus_fetch0), 48'd0);
        drain();
        chk("pf_count", 48'(fcnt), 48'd2);
        chk("l1_count", 48'(fcnt0), 48'd1);
        req = 1'b1; pc = 16'h0012;
        settle();
        chk("pf_hit", 48'(ready), 48'd1);
        chk("pf_opcode", 48'(opcode), 48'hA00009);
        chk("l1_miss", 48'(ready0), 48'd0);
        cyc = 0;
        while (!ready0 && cyc < 30) begin
            tick();
            cyc = cyc + 1;
        end
        chk("l1_opcode9", 48'(opcode0), 48'hA00009);
        chk("l1_count2", 48'(fcnt0), 48'd2);
        chk("pf_nofetch", 48'(fcnt), 48'd2);

        // Conflict: word 0x0013 evicts word 0x0003
        drain();
        req = 1'b1; pc = 16'h0006;
        wait_ready(cyc);
        chk("w3_opcode", 48'(opcode), 48'hA00003);
        drain();
        req = 1'b1; pc = 16'h0026;
        wait_ready(cyc);
        chk("w13_opcode", 48'(opcode), 48'h500013 & 48'h0 | 48'hA00013);
        drain();
        base = fcnt;
        req = 1'b1; pc = 16'h0006;
        settle();
        chk("evict_miss", 48'(ready), 48'd0);
        wait_ready(cyc);
        chk("evict_refetch", 48'(fcnt), 48'(base + 1));
        chk("evict_opcode", 48'(opcode), 48'hA00003);

        // Wrap: fill of 0x7FFF prefetches 0x0000
        drain();
        req = 1'b1; pc = 16'hFFFE;
        wait_ready(cyc);
        chk("wrap_opcode", 48'(opcode), 48'hA07FFF);
        tick();
        chk("wrap_pf_fetch", 48'(ibus_fetch), 48'd1);
        chk("wrap_pf_addr", 48'(ibus_addr), 48'h0000);
        drain();
        req = 1'b1; pc = 16'h0000;
        settle();
        chk("wrap_hit", 48'(ready), 48'd1);
        chk("wrap_hit_op", 48'(opcode), 48'hA00000);

        // Snoop invalidates a cached line
        drain();
        req = 1'b1; pc = 16'h0040;
        wait_ready(cyc);
        drain();
        snoop_write = 1'b1; snoop_addr = 15'h0020;
        tick();
        snoop_write = 1'b0;
        req = 1'b1; pc = 16'h0040;
        settle();
        chk("snoop_miss", 48'(ready), 48'd0);
        wait_ready(cyc);
        drain();

        // Snoop of the word being fetched discards the fill
        snoop_write = 1'b1; snoop_addr = 15'h0020;
        tick();
        snoop_write = 1'b0;
        base = fcnt;
        req = 1'b1; pc = 16'h0040;
        tick();
        chk("stale_fetch", 48'(ibus_addr), 48'h0020);
        snoop_write = 1'b1; snoop_addr = 15'h0020;
        tick();
        snoop_write = 1'b0;
        wait_ready(cyc);
        chk("stale_refetch", 48'(fcnt), 48'(base + 2));
        chk("stale_opcode", 48'(opcode), 48'hA00020);

        // Flush during a prefetch
        drain();
        req = 1'b1; pc = 16'h0060;
        wait_ready(cyc);
        tick();
        chk("fl_pf_addr", 48'(ibus_addr), 48'h0031);
        req = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        drain();
        req = 1'b1; pc = 16'h0062;
        settle();
        chk("fl_miss31", 48'(ready), 48'd0);
        pc = 16'h0060;
        settle();
        chk("fl_miss30", 48'(ready), 48'd0);
        wait_ready(cyc);
        chk("fl_opcode", 48'(opcode), 48'hA00030);

        // Reset during a demand miss
        drain();
        base = fcnt;
        req = 1'b1; pc = 16'h0080;
        tick();
        chk("rm_fetch", 48'(ibus_fetch), 48'd1);
        reset = 1'b1;
        tick();
        chk("rm_fetch_off", 48'(ibus_fetch), 48'd0);
        chk("rm_ready", 48'(ready), 48'd0);
        pc = 16'h0060;
        settle();
        chk("rm_invalid", 48'(ready), 48'd0);
        req = 1'b0; reset = 1'b0;
        repeat (5) tick();
        chk("rm_idle", 48'(ibus_fetch), 48'd0);
        chk("rm_no_fill", 48'(fcnt), 48'(base));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
